led_ctrl: RTL and testbench
===========================

// Module: led_ctrl
// PURPOSE
//  - Owns the 4 board LEDs and shares them between two sources:
//    - automatic activity display: PC-derived count divided by 4;
//    - CPU memory-mapped writes to a single LED register.
//  - Sits beside dmem on the MIPS data bus; decodes its own address.
//  - Sequences a timed CPU hold, a sticky CPU override, and the return to automatic display.
// PARAMETERS
//  - LED_ADDR     32'hFFFF_FF00  byte address of the LED register (word aligned)
//  - HOLD_CYCLES  50_000_000     clk cycles a non-sticky CPU pattern is shown (>=2)
//  - BLINK_CYCLES 12_500_000     half-period of the blink toggle (LED_BLINK_EN only)
//  - CNT_W        6              width of the automatic count input
// PORTS
//  - clk        in   1      system clock, rising edge
//  - reset      in   1      synchronous, active-high
//  - memwrite   in   1      data-bus write strobe, single cycle
//  - dataadr    in   32     data-bus byte address
//  - writedata  in   32     data-bus write data
//  - auto_cnt   in   CNT_W  automatic-display count
//  - led        out  4      registered LED drive
//  - led_rdata  out  32     readback value; combinational from registers
//  - led_sel    out  1      high when dataadr==LED_ADDR; used by the read mux
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - Reset state: state=AUTO, led=0, pattern=0, timer=0, blink phase=0.
//  - wr = memwrite && dataadr==LED_ADDR.
//  - writedata fields: [3:0] pattern, [4] sticky, [5] release, [6] blink.
//  - States and transitions (all registered; led reflects an event on the next edge):
//    - AUTO:
//      - led <= auto_cnt >> 2, truncated to 4 bits (unsigned; 63 -> 4'hF).
//      - wr with sticky=1 -> FORCE.
//      - other wr -> HOLD, timer <= HOLD_CYCLES-1.
//    - HOLD:
//      - led <= pattern.
//      - timer decrements each cycle; at timer==0 with no wr -> AUTO.
//    - FORCE:
//      - led <= pattern; no timer; stays until released.
//  - Write in HOLD or FORCE:
//    - release=1 overrides all other bits: -> AUTO, pattern unchanged.
//    - Otherwise pattern updates; sticky selects FORCE or HOLD.
//    - Entering or staying in HOLD reloads timer to HOLD_CYCLES-1.
//  - Simultaneous wr and timer==0: the write wins (reload or FORCE), no AUTO glitch.
//  - Reset while in HOLD or FORCE: AUTO on the next edge; timer cleared.
//  - Reads: led_rdata = {24'b0, state[1:0], blink, sticky, led[3:0]}.
//    - State encoding: AUTO=0, HOLD=1, FORCE=2.
//  - No memread handshake; the bus mux qualifies led_rdata with led_sel.
// CONFIGURATION
//  - Macro LED_BLINK_EN.
//  - Defined:
//    - writedata[6] latched as blink.
//    - In HOLD/FORCE with blink=1, led alternates pattern/0 every BLINK_CYCLES.
//    - Phase restarts at "on" on every accepted write.
//  - Undefined: bit6 ignored and reads 0; no blink counter is synthesised.
// STRUCTURE
//  - Package led_ctrl_pkg holds:
//    - state enum {AUTO, HOLD, FORCE};
//    - writedata bit positions (PAT_LSB, STICKY_BIT, RELEASE_BIT, BLINK_BIT);
//    - default LED_ADDR.
//  - Sub-module led_timer: loadable down-counter with load, enable and zero flag.
//    - Used for the hold timer and, under LED_BLINK_EN, the blink timer.
// TESTING  (bench: HOLD_CYCLES=8, BLINK_CYCLES=2)
//  - Reset, auto_cnt=6'd37: led=0 during reset; led=4'h9 one cycle after reset drops.
//  - wr 32'h5 in AUTO: led=4'h5 for exactly 8 cycles, then auto_cnt>>2.
//  - wr 32'h1A (sticky, pattern A): led=4'hA held 100 cycles.
//    - Then wr 32'h20: AUTO next cycle; readback state=0.
//  - In HOLD, wr 32'h3 on the cycle timer==0: led=4'h3; a new 8-cycle hold starts.
//  - Reset asserted mid-FORCE: led=0, state=AUTO; later wr 32'h20 is harmless.
//  - LED_BLINK_EN, wr 32'h5C (blink, sticky, C): led C,C,0,0,C,C...
//    - Without the macro: steady C; readback bit6=0.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED controller: FSM state encoding,
// writedata field positions and the default register address.
// No logic; imported by led_ctrl.
package led_ctrl_pkg;

  // Encoding is visible to software through the readback register.
  typedef enum logic [1:0] {
    AUTO  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } led_state_e;

  // writedata field layout of the LED register
  localparam int PAT_LSB     = 0;
  localparam int PAT_W       = 4;
  localparam int STICKY_BIT  = 4;
  localparam int RELEASE_BIT = 5;
  localparam int BLINK_BIT   = 6;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_FF00;

endpackage

// File: rtl/led_timer.sv
// Loadable down-counter with a zero flag; load has priority over enable.
// Latency: count updates on the edge after load/en; zero is combinational from the count.
// No backpressure; the counter saturates at zero.
module led_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: reload, decrement, or hold (never wraps below zero).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_ctrl.sv
// Board LED owner: automatic activity display vs CPU-written pattern (timed hold / sticky force).
// Latency: led is registered and reflects a bus write or state change on the next clk edge.
// No backpressure; writes are always accepted. Optional blink feature under macro LED_BLINK_EN.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [31:0] LED_ADDR     = LED_ADDR_DEFAULT,
  parameter int          HOLD_CYCLES  = 50_000_000,
  parameter int          BLINK_CYCLES = 12_500_000,
  parameter int          CNT_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  input  logic [CNT_W-1:0] auto_cnt,
  output logic [3:0]       led,
  output logic [31:0]      led_rdata,
  output logic             led_sel
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  led_state_e       state_d, state_q;
  logic [PAT_W-1:0] pattern_d, pattern_q;
  logic             sticky_d, sticky_q;
  logic [3:0]       led_d, led_q;
  logic             wr, wr_rel, wr_acc;
  logic             hold_load, hold_en, hold_zero;
  logic             blink_mask, blink_bit;

  assign led_sel = (dataadr == LED_ADDR);
  assign wr      = memwrite && led_sel;
  // A release write wins over every other field and never touches the pattern.
  assign wr_rel  = wr && writedata[RELEASE_BIT];
  assign wr_acc  = wr && !writedata[RELEASE_BIT];

  // Next-state: a write always beats hold expiry, so there is no AUTO glitch on timer==0.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    sticky_d  = sticky_q;
    hold_load = 1'b0;
    if (wr_rel) begin
      state_d = AUTO;
    end else if (wr_acc) begin
      pattern_d = writedata[PAT_LSB +: PAT_W];
      sticky_d  = writedata[STICKY_BIT];
      state_d   = writedata[STICKY_BIT] ? FORCE : HOLD;
      hold_load = !writedata[STICKY_BIT];
    end else begin
      case (state_q)
        AUTO:    state_d = AUTO;
        HOLD:    state_d = hold_zero ? AUTO : HOLD;
        FORCE:   state_d = FORCE;
        default: state_d = AUTO;
      endcase
    end
  end

  assign hold_en = (state_q == HOLD) && !hold_zero;

  led_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .en       (hold_en),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero)
  );

`ifdef LED_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

  logic blink_d, blink_q, phase_d, phase_q;
  logic blink_load, blink_en, blink_zero;
  logic unused_wd;

  // Blink phase: restart "on" at every accepted write, flip each BLINK_CYCLES while shown.
  always_comb begin
    blink_d    = blink_q;
    phase_d    = phase_q;
    blink_load = 1'b0;
    blink_en   = 1'b0;
    if (wr_acc) begin
      blink_d    = writedata[BLINK_BIT];
      phase_d    = 1'b1;
      blink_load = 1'b1;
    end else if ((state_q != AUTO) && blink_q) begin
      if (blink_zero) begin
        phase_d    = !phase_q;
        blink_load = 1'b1;
      end else begin
        blink_en = 1'b1;
      end
    end
  end

  // Blink enable and phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  led_timer #(.W(BLINK_W)) u_blink_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (blink_load),
    .en       (blink_en),
    .load_val (BLINK_LOAD),
    .zero     (blink_zero)
  );

  assign blink_mask = blink_d && !phase_d;
  assign blink_bit  = blink_q;
  assign unused_wd  = ^writedata[31:7];
`else
  logic unused_wd;
  assign blink_mask = 1'b0;
  assign blink_bit  = 1'b0;
  assign unused_wd  = ^writedata[31:6];
`endif

  // LED drive is computed from the next state so it tracks events with one edge of latency.
  always_comb begin
    led_d = led_q;
    if (state_d == AUTO) begin
      led_d = 4'(auto_cnt >> 2);
    end else if (blink_mask) begin
      led_d = 4'h0;
    end else begin
      led_d = pattern_d;
    end
  end

  // Controller registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= AUTO;
      pattern_q <= '0;
      sticky_q  <= 1'b0;
      led_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      sticky_q  <= sticky_d;
      led_q     <= led_d;
    end
  end

  assign led       = led_q;
  assign led_rdata = {24'b0, state_q, blink_bit, sticky_q, led_q};

endmodule

// File: tb/tb_led_ctrl.sv
module tb_led_ctrl;

  localparam logic [31:0] ADDR = 32'hFFFF_FF00;
  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [5:0]  auto_cnt = '0;
  logic [3:0]  led;
  logic [31:0] led_rdata;
  logic        led_sel;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0=auto 1=timed 2=forced; "shown" counts cycles the
  // pattern has been displayed in timed mode, "age" counts cycles since the last write.
  int         m_mode = 0;
  logic [3:0] m_pat = 0;
  logic [3:0] m_led = 0;
  bit         m_sticky = 0;
  bit         m_blink = 0;
  int         m_shown = 0;
  int         m_age = 0;

  led_ctrl #(
    .LED_ADDR     (ADDR),
    .HOLD_CYCLES  (HOLD),
    .BLINK_CYCLES (BLINK),
    .CNT_W        (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .auto_cnt  (auto_cnt),
    .led       (led),
    .led_rdata (led_rdata),
    .led_sel   (led_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit mw, input logic [31:0] a,
                            input logic [31:0] wd, input logic [5:0] ac);
    bit wr;
    if (r) begin
      m_mode = 0; m_pat = 0; m_sticky = 0; m_blink = 0; m_shown = 0; m_age = 0;
      m_led = 0;
      return;
    end
    wr = mw && (a == ADDR);
    if (wr && wd[5]) begin
      m_mode = 0;
    end else if (wr) begin
      m_pat    = wd[3:0];
      m_sticky = wd[4];
`ifdef LED_BLINK_EN
      m_blink  = wd[6];
`else
      m_blink  = 0;
`endif
      m_age    = 0;
      m_shown  = 1;
      m_mode   = wd[4] ? 2 : 1;
    end else if (m_mode == 1) begin
      if (m_shown >= HOLD) m_mode = 0;
      else m_shown++;
      m_age++;
    end else if (m_mode == 2) begin
      m_age++;
    end
    if (m_mode == 0) m_led = ac / 4;
    else if (m_blink && ((m_age / BLINK) % 2 == 1)) m_led = 4'h0;
    else m_led = m_pat;
  endtask

  // One clock of stimulus, followed by model update and checks.
  task automatic step(input bit r, input bit mw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [5:0] ac);
    logic [31:0] exp_rd;
    @(negedge clk);
    reset = r; memwrite = mw; dataadr = a; writedata = wd; auto_cnt = ac;
    #1;
    chk("led_sel", {31'b0, led_sel}, {31'b0, (a == ADDR)});
    @(posedge clk);
    model_edge(r, mw, a, wd, ac);
    #1;
    exp_rd = {24'b0, 2'(m_mode), m_blink, m_sticky, m_led};
    chk("led", {28'b0, led}, {28'b0, m_led});
    chk("rdata", led_rdata, exp_rd);
  endtask

  task automatic idle(input logic [5:0] ac);
    step(0, 0, 32'h0, 32'h0, ac);
  endtask

  task automatic wr(input logic [31:0] wd, input logic [5:0] ac);
    step(0, 1, ADDR, wd, ac);
  endtask

  logic [3:0] blink_seq [6];

  initial begin
    // Reset with auto_cnt=37: dark during reset, 37>>2=9 one edge after release.
    repeat (3) step(1, 0, 32'h0, 32'h0, 6'd37);
    chk("reset_led", {28'b0, led}, 32'h0);
    chk("reset_state", {30'b0, led_rdata[7:6]}, 32'h0);
    idle(6'd37);
    chk("auto_37", {28'b0, led}, 32'h9);

    // Timed hold: pattern 5 for exactly HOLD cycles.
    wr(32'h5, 6'd37);
    chk("hold_first", {28'b0, led}, 32'h5);
    repeat (HOLD - 1) idle(6'd37);
    chk("hold_last", {28'b0, led}, 32'h5);
    idle(6'd37);
    chk("hold_expire", {28'b0, led}, 32'h9);

    // Sticky A survives 100 cycles, then release returns to auto.
    wr(32'h1A, 6'd20);
    repeat (100) idle(6'd20);
    chk("force_held", {28'b0, led}, 32'hA);
    chk("force_state", {30'b0, led_rdata[7:6]}, 32'h2);
    wr(32'h20, 6'd20);
    chk("release_led", {28'b0, led}, 32'h5);
    chk("release_state", {30'b0, led_rdata[7:6]}, 32'h0);

    // Write on the timer==0 cycle wins and starts a fresh hold.
    wr(32'h5, 6'd44);
    repeat (HOLD - 1) idle(6'd44);
    wr(32'h3, 6'd44);
    chk("reload_led", {28'b0, led}, 32'h3);
    repeat (HOLD - 1) idle(6'd44);
    chk("reload_last", {28'b0, led}, 32'h3);
    idle(6'd44);
    chk("reload_expire", {28'b0, led}, 32'hB);

    // Reset mid-force, then a stray release is harmless.
    wr(32'h1A, 6'd8);
    repeat (3) idle(6'd8);
    step(1, 0, 32'h0, 32'h0, 6'd8);
    chk("rst_force_led", {28'b0, led}, 32'h0);
    wr(32'h20, 6'd8);
    chk("rel_after_rst", {28'b0, led}, 32'h2);
    chk("rel_after_rst_st", {30'b0, led_rdata[7:6]}, 32'h0);

    // Blink request (sticky C).
`ifdef LED_BLINK_EN
    blink_seq = '{4'hC, 4'hC, 4'h0, 4'h0, 4'hC, 4'hC};
`else
    blink_seq = '{4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC};
`endif
    wr(32'h5C, 6'd0);
    chk("blink_0", {28'b0, led}, {28'b0, blink_seq[0]});
`ifndef LED_BLINK_EN
    chk("blink_bit6", {31'b0, led_rdata[6]}, 32'h0);
`endif
    for (int i = 1; i < 6; i++) begin
      idle(6'd0);
      chk($sformatf("blink_%0d", i), {28'b0, led}, {28'b0, blink_seq[i]});
    end
    wr(32'h20, 6'd12);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit          r, mw;
      logic [31:0] a, wd;
      r  = ($urandom_range(0, 79) == 0);
      mw = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 4) != 0) ? ADDR : $urandom;
      wd = $urandom;
      wd[5] = ($urandom_range(0, 3) == 0);
      step(r, mw, a, wd, 6'($urandom_range(0, 63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
